rxuart_mv_fifo: RTL
===================

Name: rxuart_mv_fifo

Overview:
Parametrised UART receiver, successor to the single-byte receiver.
- Character width up to DW bits, selectable at run time.
- 3-sample majority vote per bit and false-start rejection.
- Built-in receive FIFO with per-entry error flags and a valid/ready pop interface.
- Sticky overflow flag and an idle-line timeout indication.
- Sits between the pad synchroniser and the bus-side UART register block.

Parameters:
CLKW, 24, width of the clocks-per-baud field and of the bit-timing counters.
DW, 9, maximum data bits per character (5..9).
LGFLEN, 4, log2 of FIFO depth (depth 16).
BREAK_BAUDS, 16, bit times of continuous low that signal a break; also bit times of continuous high needed for line sync.
TIMEOUT_BAUDS, 32, idle bit times with a non-empty FIFO before o_timeout asserts.
INITIAL_SETUP, {8'h08,24'd868}, setup value at reset: 8N1, 868 clocks per baud.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_setup  in  CLKW+8  setup bus:
- [CLKW-1:0] clocks per baud (CPB), minimum 16.
- [CLKW+3:CLKW] nbits, 5..DW; out-of-range values are clamped.
- [CLKW+4] use_parity.
- [CLKW+5] fixed_parity.
- [CLKW+6] parity_even.
- [CLKW+7] dblstop.
i_uart_rx  in  1  asynchronous serial line
i_ready  in  1  consumer pops the FIFO head when o_valid && i_ready
i_clr_ovf  in  1  clears o_overflow
o_valid  out  1  FIFO not empty
o_data  out  DW  head character, LSB = first received bit, unused upper bits 0
o_perr  out  1  parity error flag of the head entry
o_ferr  out  1  framing error flag of the head entry
o_fill  out  LGFLEN+1  FIFO occupancy
o_overflow  out  1  sticky: a character was dropped because the FIFO was full
o_break  out  1  break in progress
o_timeout  out  1  idle timeout with data pending

Behaviour:
Synchroniser and setup
- i_uart_rx passes through a 3-flop synchroniser; "line" means the synchronised value.
- Setup is latched only in RESET_IDLE or IDLE; changes mid-frame take effect at the next frame.

Reset values
- FIFO empty; o_valid=0, o_data=0, o_perr=0, o_ferr=0, o_fill=0, o_overflow=0, o_break=0, o_timeout=0.
- State=RESET_IDLE.

States: RESET_IDLE, IDLE, START, DATA, PARITY, STOP, STOP2, BREAK.
- RESET_IDLE -> IDLE: line high continuously for BREAK_BAUDS*CPB cycles.
- IDLE -> START: falling edge on line. The bit counter starts at 0.
- Sampling instants: each bit k (start bit = 0) is sampled at cycles k*CPB + CPB/2 - 1, +0 and +1 after the edge. The bit value is the majority of the 3 samples, decided at the third sample.
- START, majority 1: false start, return to IDLE, no FIFO write.
- START, majority 0: go to DATA.
- DATA: take nbits bits, shifted in LSB first.
- After DATA: go to PARITY if use_parity, else STOP.
- Parity check:
  - fixed_parity: the bit must equal parity_even.
  - even parity: XOR of data and parity must be 0.
  - odd parity: XOR of data and parity must be 1.
- STOP: ferr = stop majority is 0. STOP2 (only if dblstop) also ORs its bit into ferr.
- After the last stop decision, the character is pushed the next cycle. State returns to IDLE, or to RESET_IDLE if the last stop bit was 0.
- Any state other than RESET_IDLE -> BREAK when line has been low for BREAK_BAUDS*CPB cycles. While in BREAK: o_break=1 and no pushes.
- BREAK -> IDLE when line goes high; o_break clears the same cycle the state leaves.

FIFO
- Entry = {ferr, perr, data}.
- Push the cycle after the final stop decision; o_valid/o_data reflect the entry on the following cycle (2-cycle latency from stop decision).
- Pop on o_valid && i_ready.
- Push when full and no pop: character dropped, o_overflow <= 1.
- Push and pop in the same cycle when full: both accepted, fill unchanged.
- Pointers wrap modulo 2^LGFLEN.
- i_clr_ovf clears o_overflow; a new overflow in the same cycle wins.

Timeout
- Idle counter resets on any line edge or pop.
- o_timeout=1 when o_valid && the counter reaches TIMEOUT_BAUDS*CPB.
- Clears on pop, on a falling edge, or when the FIFO empties.

Reset mid-frame
- The partial character is discarded and the FIFO is flushed.
- State goes to RESET_IDLE and the setup reloads on the next cycle.

Test Plan:
8N1, CPB=16, send 0x55 then 0xA3 after sync -> two entries 0x055/0x0A3, perr=ferr=0; o_valid rises 2 cycles after the stop-bit third sample.
8E1, send 0x07 with parity bit 0 -> o_data=0x07, o_perr=1, o_ferr=0. Send 0x07 with parity 1 -> o_perr=0.
3-cycle low pulse on an idle line -> no entry, state back in IDLE. 1-cycle high glitch at the center sample of data bit 3 of 0x00 -> majority keeps the bit 0, o_data=0x00.
9-bit mode (nbits=9), send 0x1A5 -> o_data=0x1A5. Then nbits=5, send 0x1F -> o_data=0x01F, upper bits 0.
i_ready=0, send 17 characters with LGFLEN=4 -> o_fill=16, o_overflow=1, characters 1..16 intact. Pulse i_clr_ovf -> o_overflow=0.
Line low for 16*CPB -> o_break=1, one entry 0x00 with ferr=1, nothing more. Release the line -> o_break=0, and the next character is received normally.
One byte left unread, TIMEOUT_BAUDS=32 -> o_timeout=1 after 32*CPB idle cycles, 0 after a pop.
Assert i_reset mid-character -> FIFO empty, no entry, RESET_IDLE until the 16*CPB high sync completes.

Source files
------------

// File: rtl/rxuart_mv_fifo.sv
`default_nettype none
// ============================================================================
// rxuart_mv_fifo : UART receiver, 3-sample majority vote, break/timeout, FIFO
// Rev 1.0
// ============================================================================
module rxuart_mv_fifo #(
  parameter int              CLKW          = 24,
  parameter int              DW            = 9,
  parameter int              LGFLEN        = 4,
  parameter int              BREAK_BAUDS   = 16,
  parameter int              TIMEOUT_BAUDS = 32,
  parameter logic [CLKW+7:0] INITIAL_SETUP = {8'h08, 24'd868}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [CLKW+7:0]   i_setup,
  input  logic              i_uart_rx,
  input  logic              i_ready,
  input  logic              i_clr_ovf,
  output logic              o_valid,
  output logic [DW-1:0]     o_data,
  output logic              o_perr,
  output logic              o_ferr,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_overflow,
  output logic              o_break,
  output logic              o_timeout
);

  localparam int c_RW    = CLKW + $clog2(BREAK_BAUDS) + 1;
  localparam int c_TW    = CLKW + $clog2(TIMEOUT_BAUDS) + 1;
  localparam int c_DEPTH = 1 << LGFLEN;

  typedef enum logic [2:0] {
    S_RESET_IDLE = 3'd0,
    S_IDLE       = 3'd1,
    S_START      = 3'd2,
    S_DATA       = 3'd3,
    S_PARITY     = 3'd4,
    S_STOP       = 3'd5,
    S_STOP2      = 3'd6,
    S_BREAK      = 3'd7
  } state_t;

  state_t              r_state;
  logic [2:0]          r_sync;
  logic                r_line_q;
  logic [CLKW+7:0]     r_setup;
  logic [CLKW-1:0]     r_cnt;
  logic [3:0]          r_bitn;
  logic [DW-1:0]       r_shift;
  logic                r_par, r_s0, r_s1, r_perr, r_ferr, r_push, r_break;
  logic [c_RW-1:0]     r_run;
  logic                r_brk_ok;
  logic [c_TW-1:0]     r_idle;
  logic                r_timeout;
  logic                r_ovf;
  logic [DW+1:0]       r_mem [c_DEPTH];
  logic [LGFLEN-1:0]   r_wptr, r_rptr;
  logic [LGFLEN:0]     r_fill;

  logic                w_line, w_chg, w_fall, w_maj, w_dec, w_run_full, w_brk_go;
  logic [CLKW-1:0]     w_cpb, w_half;
  logic [3:0]          w_nb_raw, w_nbits;
  logic                w_use_par, w_fixed, w_even, w_dbl;
  logic [c_RW-1:0]     w_brk_lim;
  logic [c_TW-1:0]     w_to_lim;
  logic [DW-1:0]       w_char;
  logic                w_valid, w_full, w_pop, w_wr;
  logic [DW+1:0]       w_head;

  assign w_line    = r_sync[2];
  assign w_chg     = w_line ^ r_line_q;
  assign w_fall    = r_line_q & ~w_line;

  assign w_cpb     = r_setup[CLKW-1:0];
  assign w_half    = w_cpb >> 1;
  assign w_nb_raw  = r_setup[CLKW+3:CLKW];
  assign w_nbits   = (w_nb_raw < 4'd5) ? 4'd5 : ((w_nb_raw > 4'(DW)) ? 4'(DW) : w_nb_raw);
  assign w_use_par = r_setup[CLKW+4];
  assign w_fixed   = r_setup[CLKW+5];
  assign w_even    = r_setup[CLKW+6];
  assign w_dbl     = r_setup[CLKW+7];

  assign w_brk_lim = c_RW'(BREAK_BAUDS) * c_RW'(w_cpb);
  assign w_to_lim  = c_TW'(TIMEOUT_BAUDS) * c_TW'(w_cpb);

  // Bit decided on the third of the three centre samples
  assign w_dec = (r_cnt == w_half + CLKW'(1));
  assign w_maj = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);

  assign w_run_full = ~w_chg && (r_run >= w_brk_lim - c_RW'(1));
  // A low run that began during a frame may still become a break after a bad stop bit
  assign w_brk_go   = ~w_line && w_run_full && (r_state != S_BREAK)
                      && ((r_state != S_RESET_IDLE) || r_brk_ok);

  assign w_char = r_shift >> (4'(DW) - w_nbits);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync   <= 3'b111;
      r_line_q <= 1'b1;
      r_run    <= '0;
      r_brk_ok <= 1'b0;
    end else begin
      r_sync   <= {r_sync[1:0], i_uart_rx};
      r_line_q <= w_line;
      if (w_chg)
        r_run <= c_RW'(1);
      else if (r_run < w_brk_lim)
        r_run <= r_run + c_RW'(1);
      if (w_line)
        r_brk_ok <= 1'b0;
      else if (r_state != S_RESET_IDLE)
        r_brk_ok <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    r_push <= 1'b0;
    if (i_reset) begin
      r_state <= S_RESET_IDLE;
      r_setup <= INITIAL_SETUP;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_break <= 1'b0;
      r_push  <= 1'b0;
    end else begin
      if (r_state == S_RESET_IDLE || r_state == S_IDLE)
        r_setup <= i_setup;
      if (r_state != S_RESET_IDLE && r_state != S_IDLE && r_state != S_BREAK) begin
        r_cnt <= (r_cnt == w_cpb - CLKW'(1)) ? '0 : r_cnt + CLKW'(1);
        if (r_cnt == w_half - CLKW'(1)) r_s0 <= w_line;
        if (r_cnt == w_half)            r_s1 <= w_line;
      end
      if (w_brk_go) begin
        r_state <= S_BREAK;
        r_break <= 1'b1;
      end else begin
        case (r_state)
          S_RESET_IDLE: if (w_line && w_run_full) r_state <= S_IDLE;
          S_IDLE: if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= CLKW'(1);
            r_bitn  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
          end
          S_START: if (w_dec) r_state <= w_maj ? S_IDLE : S_DATA;
          S_DATA: if (w_dec) begin
            r_shift <= {w_maj, r_shift[DW-1:1]};
            r_par   <= r_par ^ w_maj;
            r_bitn  <= r_bitn + 4'd1;
            if (r_bitn == w_nbits - 4'd1)
              r_state <= w_use_par ? S_PARITY : S_STOP;
          end
          S_PARITY: if (w_dec) begin
            r_perr  <= w_fixed ? (w_maj != w_even) : (r_par ^ w_maj ^ ~w_even);
            r_state <= S_STOP;
          end
          S_STOP: if (w_dec) begin
            r_ferr <= ~w_maj;
            if (w_dbl) begin
              r_state <= S_STOP2;
            end else begin
              r_push  <= 1'b1;
              r_state <= w_maj ? S_IDLE : S_RESET_IDLE;
            end
          end
          S_STOP2: if (w_dec) begin
            r_ferr  <= r_ferr | ~w_maj;
            r_push  <= 1'b1;
            r_state <= w_maj ? S_IDLE : S_RESET_IDLE;
          end
          S_BREAK: if (w_line) begin
            r_state <= S_IDLE;
            r_break <= 1'b0;
          end
          default: r_state <= S_RESET_IDLE;
        endcase
      end
    end
  end

  assign w_valid = (r_fill != '0);
  assign w_full  = (r_fill == (LGFLEN+1)'(c_DEPTH));
  assign w_pop   = w_valid & i_ready;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wptr] <= {r_ferr, r_perr, w_char};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)
        r_fill <= r_fill + 1'b1;
      else if (!w_wr && w_pop)
        r_fill <= r_fill - 1'b1;
      if (r_push && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (i_clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_chg || w_pop)
        r_idle <= '0;
      else if (r_idle < w_to_lim)
        r_idle <= r_idle + c_TW'(1);
      if (w_pop || w_fall || !w_valid)
        r_timeout <= 1'b0;
      else if (r_idle >= w_to_lim)
        r_timeout <= 1'b1;
    end
  end

  assign o_valid    = w_valid;
  assign o_data     = w_valid ? w_head[DW-1:0] : '0;
  assign o_perr     = w_valid & w_head[DW];
  assign o_ferr     = w_valid & w_head[DW+1];
  assign o_fill     = r_fill;
  assign o_overflow = r_ovf;
  assign o_break    = r_break;
  assign o_timeout  = r_timeout;

endmodule
`default_nettype wire
